// File: rtl/state_dumper.sv
// Debug state dumper: streams a 44-word frame (counters, PC, x0..x31, dmem 0x00..0x1C) through a
// registered valid/ready slot; first word valid 1 cycle after the request, slot holds while ready is low.
module state_dumper (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic        dump_req_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [4:0]  mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic [31:0] dout_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic        dout_last_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_REG, S_MEM} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cyc, r_stl, r_flu;
  logic [31:0] r_snap_stl, r_snap_flu, r_snap_pc;
  logic [5:0]  r_idx, w_idx_nxt, w_idx_inc;
  logic [31:0] r_dout, w_dout_nxt, w_word;
  logic        r_vld, w_vld_nxt, r_last, w_last_nxt;
  logic        w_start, w_load, w_xfer;

  // r_idx is the index of the next word to be loaded into the slot; 44 means all loaded.
  assign w_start   = (r_state == S_IDLE) && dump_req_i;
  assign w_xfer    = r_vld && dout_ready_i;
  assign w_load    = (r_state != S_IDLE) && (r_idx < 6'd44) && (!r_vld || dout_ready_i);
  assign w_idx_inc = r_idx + 6'd1;

  assign reg_addr_o = (r_state == S_REG) ? (r_idx[4:0] - 5'd4) : 5'd0;
  assign mem_addr_o = (r_state == S_MEM) ? {r_idx[2:0] - 3'd4, 2'b00} : 5'd0;

  always_comb begin
    w_word = mem_data_i;
    if (r_idx == 6'd1)      w_word = r_snap_stl;
    else if (r_idx == 6'd2) w_word = r_snap_flu;
    else if (r_idx == 6'd3) w_word = r_snap_pc;
    else if (r_idx < 6'd36) w_word = reg_data_i;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dout_nxt  = r_dout;
    w_vld_nxt   = r_vld;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        // Word 0 is the pre-increment cycle count, loaded on the request edge itself.
        if (dump_req_i) begin
          w_state_nxt = S_HDR;
          w_idx_nxt   = 6'd1;
          w_dout_nxt  = r_cyc;
          w_vld_nxt   = 1'b1;
          w_last_nxt  = 1'b0;
        end
      end
      default: begin
        if (w_xfer) begin
          w_vld_nxt  = 1'b0;
          w_last_nxt = 1'b0;
        end
        if (w_load) begin
          w_idx_nxt  = w_idx_inc;
          w_dout_nxt = w_word;
          w_vld_nxt  = 1'b1;
          w_last_nxt = (r_idx == 6'd43);
          if (w_idx_inc < 6'd4)       w_state_nxt = S_HDR;
          else if (w_idx_inc < 6'd36) w_state_nxt = S_REG;
          else                        w_state_nxt = S_MEM;
        end else if (w_xfer && r_last) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_stl      <= '0;
      r_flu      <= '0;
      r_snap_stl <= '0;
      r_snap_flu <= '0;
      r_snap_pc  <= '0;
      r_idx      <= '0;
      r_dout     <= '0;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      if (start_i && (r_cyc != 32'hFFFF_FFFF)) r_cyc <= r_cyc + 32'd1;
      if (stall_i && (r_stl != 32'hFFFF_FFFF)) r_stl <= r_stl + 32'd1;
      if (flush_i && (r_flu != 32'hFFFF_FFFF)) r_flu <= r_flu + 32'd1;
      if (w_start) begin
        r_snap_stl <= r_stl;
        r_snap_flu <= r_flu;
        r_snap_pc  <= pc_i;
      end
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_dout  <= w_dout_nxt;
      r_vld   <= w_vld_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign dout_o       = r_dout;
  assign dout_valid_o = r_vld;
  assign dout_last_o  = r_last;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_state_dumper.sv
// Bench for state_dumper: directed frames, scoreboard queue filled at request time,
// negedge monitor pops and compares each accepted word.
module tb_state_dumper;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, stall_i, flush_i, dump_req_i, dout_ready_i;
  logic [31:0] pc_i, reg_data_i, mem_data_i, dout_o;
  logic [4:0]  reg_addr_o, mem_addr_o;
  logic        dout_valid_o, dout_last_o, busy_o;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          errs = 0;
  logic [31:0] rf [32];
  logic [7:0]  mb [32];

  always #5 clk_i = ~clk_i;

  state_dumper dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .flush_i(flush_i), .pc_i(pc_i), .dump_req_i(dump_req_i),
    .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
    .dout_last_o(dout_last_o), .busy_o(busy_o)
  );

  assign reg_data_i = rf[reg_addr_o];
  assign mem_data_i = {mb[{mem_addr_o[4:2], 2'd3}], mb[{mem_addr_o[4:2], 2'd2}],
                       mb[{mem_addr_o[4:2], 2'd1}], mb[{mem_addr_o[4:2], 2'd0}]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] c, input logic [31:0] s,
                            input logic [31:0] f, input logic [31:0] pc);
    exp_t e;
    e.l = 1'b0;
    e.d = c;  q.push_back(e);
    e.d = s;  q.push_back(e);
    e.d = f;  q.push_back(e);
    e.d = pc; q.push_back(e);
    for (int i = 0; i < 32; i++) begin
      e.d = rf[i];
      q.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      e.d = {mb[4*k+3], mb[4*k+2], mb[4*k+1], mb[4*k]};
      e.l = (k == 7);
      q.push_back(e);
    end
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && dout_valid_o && dout_ready_i) begin
      if (q.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_word: got %h expected none", dout_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("word_dat", dout_o, e.d);
        chk("word_last", {31'd0, dout_last_o}, {31'd0, e.l});
      end
    end
  end

  // Request edge plus 44 full-rate cycles; optional re-request while busy at word req_at.
  task automatic run_frame(input int req_at);
    int bubbles, badlast;
    bubbles = 0;
    badlast = 0;
    @(posedge clk_i); #1;
    dump_req_i = 1'b0;
    chk("latency_vld", {31'd0, dout_valid_o}, 32'd1);
    chk("busy_on", {31'd0, busy_o}, 32'd1);
    for (int k = 0; k < 44; k++) begin
      dump_req_i = (k == req_at);
      @(negedge clk_i);
      if (!dout_valid_o) bubbles++;
      if (dout_last_o !== (k == 43)) badlast++;
      if (k == 8)  chk("reg_addr_w9", {27'd0, reg_addr_o}, 32'd5);
      if (k == 36) chk("mem_addr_w37", {27'd0, mem_addr_o}, 32'd4);
      @(posedge clk_i); #1;
    end
    dump_req_i = 1'b0;
    chk("bubbles", bubbles, 0);
    chk("last_pos", badlast, 0);
    chk("vld_off", {31'd0, dout_valid_o}, 32'd0);
    chk("busy_off", {31'd0, busy_o}, 32'd0);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          c, xfers, unstable, idle_vld;
    logic        held, done;
    logic [3:0]  pat;
    logic [31:0] sv_d;
    logic        sv_v, sv_l;

    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'hA000_0000 | i;
      mb[i] = 8'hC0 + 8'(i);
    end
    rf[5] = 32'h1234_5678;
    mb[4] = 8'h78; mb[5] = 8'h56; mb[6] = 8'h34; mb[7] = 8'h12;

    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    dump_req_i = 1'b0; dout_ready_i = 1'b1; pc_i = 32'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_vld", {31'd0, dout_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_last", {31'd0, dout_last_o}, 32'd0);
    chk("rst_dout", dout_o, 32'd0);
    chk("rst_raddr", {27'd0, reg_addr_o}, 32'd0);
    chk("rst_maddr", {27'd0, mem_addr_o}, 32'd0);

    // Basic dump: 10 running cycles, PC 0x28.
    @(posedge clk_i); #1;
    rst_i = 1'b1; start_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1 start_i = 1'b0;
    pc_i = 32'h28;
    @(posedge clk_i); #1;
    dump_req_i = 1'b1;
    push_frame(32'd10, 32'd0, 32'd0, 32'h28);
    run_frame(-1);

    // Counter events: 3 stalls, 2 flushes.
    for (int i = 0; i < 3; i++) begin
      stall_i = 1'b1; @(posedge clk_i); #1;
      stall_i = 1'b0; @(posedge clk_i); #1;
    end
    for (int i = 0; i < 2; i++) begin
      flush_i = 1'b1; @(posedge clk_i); #1;
      flush_i = 1'b0; @(posedge clk_i); #1;
    end
    pc_i = 32'h100;
    dump_req_i = 1'b1;
    push_frame(32'd10, 32'd3, 32'd2, 32'h100);
    run_frame(-1);

    // Backpressure with ready pattern 1,0,0,1.
    pc_i = 32'h200;
    dump_req_i = 1'b1;
    push_frame(32'd10, 32'd3, 32'd2, 32'h200);
    @(posedge clk_i); #1;
    dump_req_i = 1'b0;
    pat = 4'b1001;
    c = 0; xfers = 0; unstable = 0; held = 1'b0; done = 1'b0;
    sv_d = '0; sv_v = 1'b0; sv_l = 1'b0;
    while (!done && c < 400) begin
      dout_ready_i = pat[c % 4];
      @(negedge clk_i);
      if (held && (dout_o !== sv_d || dout_valid_o !== sv_v || dout_last_o !== sv_l)) unstable++;
      held = dout_valid_o && !dout_ready_i;
      sv_d = dout_o; sv_v = dout_valid_o; sv_l = dout_last_o;
      if (dout_valid_o && dout_ready_i) begin
        xfers++;
        if (dout_last_o) done = 1'b1;
      end
      @(posedge clk_i); #1;
      c++;
    end
    dout_ready_i = 1'b1;
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_xfers", xfers, 44);
    chk("bp_unstable", unstable, 0);
    chk("bp_vld_off", {31'd0, dout_valid_o}, 32'd0);
    chk("bp_queue_empty", q.size(), 0);

    // Request while busy is dropped; counters keep running during the dump (1 + 44 edges).
    pc_i = 32'h280;
    start_i = 1'b1;
    dump_req_i = 1'b1;
    push_frame(32'd10, 32'd3, 32'd2, 32'h280);
    run_frame(20);
    start_i = 1'b0;
    idle_vld = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (dout_valid_o || busy_o) idle_vld++;
      @(posedge clk_i); #1;
    end
    chk("no_queued_req", idle_vld, 0);

    // Reset in the middle of a frame (at word 30).
    pc_i = 32'h300;
    dump_req_i = 1'b1;
    push_frame(32'd55, 32'd3, 32'd2, 32'h300);
    @(posedge clk_i); #1;
    dump_req_i = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      if (k == 30) rst_i = 1'b0;
      @(negedge clk_i);
      @(posedge clk_i); #1;
    end
    chk("abort_vld", {31'd0, dout_valid_o}, 32'd0);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_dout", dout_o, 32'd0);
    chk("abort_popped", q.size(), 44 - 30);
    q.delete();

    // Fresh frame after reset: counters restart from zero.
    rst_i = 1'b1; start_i = 1'b1;
    repeat (7) @(posedge clk_i);
    #1 start_i = 1'b0;
    pc_i = 32'h44;
    dump_req_i = 1'b1;
    push_frame(32'd7, 32'd0, 32'd0, 32'h44);
    run_frame(-1);

    repeat (3) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
